// File: rtl/sram_rd_arbiter.sv
// sram_rd_arbiter: shares one SRAM read port between two read requesters
// using round-robin arbitration. Writes pass straight through to the SRAM
// write port. A read that hits the address being written in the same cycle
// returns the new write data through a one-entry bypass.
//
// Handshake: a read requester raises rdN_req with a stable rdN_addr and holds
// both until it sees rdN_gnt high in the same cycle. The grant is the
// transfer. Exactly one cycle later rdN_valid pulses for one cycle with
// rdN_data. Writes are always accepted (wr_gnt mirrors wr_req).
module sram_rd_arbiter #(
  parameter int DWIDTH = 7,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  // write requester
  input  logic              wr_req,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              wr_gnt,
  // read requester 0
  input  logic              rd0_req,
  input  logic [AWIDTH-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_valid,
  output logic [DWIDTH-1:0] rd0_data,
  // read requester 1
  input  logic              rd1_req,
  input  logic [AWIDTH-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_valid,
  output logic [DWIDTH-1:0] rd1_data,
  // SRAM side
  output logic              sram_wr_en,
  output logic [AWIDTH-1:0] sram_wr_addr,
  output logic [DWIDTH-1:0] sram_d,
  output logic              sram_rd_en,
  output logic [AWIDTH-1:0] sram_rd_addr,
  input  logic [DWIDTH-1:0] sram_q
);

  // rr_q: 0 prefers rd0, 1 prefers rd1 on a contested cycle
  logic              rr_q, rr_d;
  // in-flight read: busy flag plus owner tag (0 = rd0, 1 = rd1)
  logic              busy_q, busy_d;
  logic              tag_q, tag_d;
  // same-address write bypass captured on the grant cycle
  logic              byp_q, byp_d;
  logic [DWIDTH-1:0] byp_data_q, byp_data_d;

  logic              contested;
  logic [DWIDTH-1:0] rd_word;

  // Write path is a pure pass-through; writes never stall.
  always_comb begin
    wr_gnt       = wr_req;
    sram_wr_en   = wr_req;
    sram_wr_addr = wr_addr;
    sram_d       = wr_data;
  end

  // Grant selection and SRAM read-port steering.
  always_comb begin
    contested    = rd0_req & rd1_req;
    rd0_gnt      = rd0_req & (~rd1_req | ~rr_q);
    rd1_gnt      = rd1_req & (~rd0_req |  rr_q);
    sram_rd_en   = rd0_gnt | rd1_gnt;
    sram_rd_addr = '0;
    if (rd0_gnt) begin
      sram_rd_addr = rd0_addr;
    end else if (rd1_gnt) begin
      sram_rd_addr = rd1_addr;
    end
  end

  // Next-state for pointer, in-flight tag and bypass capture.
  always_comb begin
    rr_d       = contested ? ~rr_q : rr_q;
    busy_d     = sram_rd_en;
    tag_d      = rd1_gnt;
    byp_d      = sram_rd_en & wr_req & (wr_addr == sram_rd_addr);
    byp_data_d = byp_data_q;
    if (byp_d) begin
      byp_data_d = wr_data;
    end
  end

  // State registers; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q       <= 1'b0;
      busy_q     <= 1'b0;
      tag_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      tag_q      <= tag_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Response steering: only the tagged owner sees valid; data is 0 otherwise.
  always_comb begin
    rd_word   = byp_q ? byp_data_q : sram_q;
    rd0_valid = busy_q & ~tag_q;
    rd1_valid = busy_q &  tag_q;
    rd0_data  = rd0_valid ? rd_word : '0;
    rd1_data  = rd1_valid ? rd_word : '0;
  end

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// tb_sram_rd_arbiter: directed plus constrained-random read/write traffic
// against a bench-side SRAM, checked every cycle by a transaction-level model
// and pinned by hand-computed literal expectations.
module tb_sram_rd_arbiter;
  localparam int DW = 7;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          wr_req, rd0_req, rd1_req;
  logic [AW-1:0] wr_addr, rd0_addr, rd1_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
  logic [DW-1:0] rd0_data, rd1_data;
  logic          sram_wr_en, sram_rd_en;
  logic [AW-1:0] sram_wr_addr, sram_rd_addr;
  logic [DW-1:0] sram_d, sram_q;

  sram_rd_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_d(sram_d),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_q(sram_q)
  );

  // Bench SRAM: synchronous, read-before-write on an address collision.
  logic [DW-1:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_rd_en) sram_q <= sram_mem[sram_rd_addr];
    if (sram_wr_en) sram_mem[sram_wr_addr] <= sram_d;
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory contents as seen by requesters, round-robin preference, and
  // the queue of owed responses ({owner, data}).
  logic [DW-1:0] model_mem [256];
  logic          model_pref1 = 1'b0;
  logic [DW:0]   exp_q[$];

  always @(negedge clk) begin
    logic          e_g0, e_g1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_word;
    logic [DW:0]   e;
    // write pass-through
    check("wr_gnt", wr_gnt, wr_req);
    check("sram_wr_en", sram_wr_en, wr_req);
    check("sram_wr_addr", sram_wr_addr, wr_addr);
    check("sram_d", sram_d, wr_data);
    // arbitration: lone requester wins; contested goes to the preferred side
    if (!rst) model_pref1 = 1'b0;
    e_g0 = rd0_req && (!rd1_req || !model_pref1);
    e_g1 = rd1_req && (!rd0_req || model_pref1);
    e_addr = e_g0 ? rd0_addr : (e_g1 ? rd1_addr : '0);
    check("rd0_gnt", rd0_gnt, e_g0);
    check("rd1_gnt", rd1_gnt, e_g1);
    check("sram_rd_en", sram_rd_en, e_g0 | e_g1);
    check("sram_rd_addr", sram_rd_addr, e_addr);
    // responses owed from the previous cycle
    if (!rst) exp_q.delete();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd0_valid", rd0_valid, !e[DW]);
      check("rd1_valid", rd1_valid, e[DW]);
      check("rd0_data", rd0_data, e[DW] ? '0 : e[DW-1:0]);
      check("rd1_data", rd1_data, e[DW] ? e[DW-1:0] : '0);
    end else begin
      check("rd0_valid_idle", rd0_valid, 0);
      check("rd1_valid_idle", rd1_valid, 0);
      check("rd0_data_idle", rd0_data, 0);
      check("rd1_data_idle", rd1_data, 0);
    end
    // a read sees a same-cycle write to its address
    e_word = (wr_req && wr_addr == e_addr) ? wr_data : model_mem[e_addr];
    if (rst && (e_g0 || e_g1)) exp_q.push_back({e_g1, e_word});
    if (rst && rd0_req && rd1_req) model_pref1 = ~model_pref1;
    if (wr_req) model_mem[wr_addr] = wr_data;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic r0, input logic [AW-1:0] a0,
                       input logic r1, input logic [AW-1:0] a1);
    wr_req = w;  wr_addr = wa;  wr_data = wd;
    rd0_req = r0; rd0_addr = a0;
    rd1_req = r1; rd1_addr = a1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          r0, r1, g0, g1;
    logic [AW-1:0] a0, a1;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = DW'($urandom_range(0, 127));
      model_mem[i] = sram_mem[i];
    end
    sram_mem[4] = 7'h07;  model_mem[4] = 7'h07;
    sram_mem[9] = 7'h11;  model_mem[9] = 7'h11;
    sram_q = '0;
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check("lit_reset_rd0_valid", rd0_valid, 0);
    check("lit_reset_rd1_valid", rd1_valid, 0);
    check("lit_reset_rd0_data", rd0_data, 0);
    check("lit_reset_rd1_data", rd1_data, 0);
    next_cycle(); rst = 1'b1;

    // write then read-back through rd0
    drive(1, 5, 7'h2A, 0, 0, 0, 0); @(negedge clk);
    next_cycle(); drive(0, 0, 0, 1, 5, 0, 0); @(negedge clk);
    check("lit_wr_rd_gnt", rd0_gnt, 1);
    check("lit_wr_rd_addr", sram_rd_addr, 5);
    next_cycle(); idle(); @(negedge clk);
    check("lit_wr_rd_valid", rd0_valid, 1);
    check("lit_wr_rd_data", rd0_data, 7'h2A);
    check("lit_wr_rd_other", rd1_valid, 0);

    // both requesting from reset: strict alternation
    next_cycle(); rst = 1'b0; @(negedge clk);
    next_cycle(); rst = 1'b1; drive(0, 0, 0, 1, 5, 1, 4); @(negedge clk);
    check("lit_rr_c1_g0", rd0_gnt, 1);
    next_cycle(); @(negedge clk);
    check("lit_rr_c2_g1", rd1_gnt, 1);
    check("lit_rr_c2_v0", rd0_data, 7'h2A);
    next_cycle(); @(negedge clk);
    check("lit_rr_c3_g0", rd0_gnt, 1);
    check("lit_rr_c3_v1", rd1_data, 7'h07);
    next_cycle(); @(negedge clk);
    check("lit_rr_c4_g1", rd1_gnt, 1);
    next_cycle(); idle(); @(negedge clk);
    check("lit_rr_tail_v1", rd1_valid, 1);

    // uncontested rd1 grants leave the pointer alone
    next_cycle(); drive(0, 0, 0, 0, 0, 1, 4);
    repeat (3) begin
      @(negedge clk);
      check("lit_solo_g1", rd1_gnt, 1);
      next_cycle();
    end
    drive(0, 0, 0, 1, 5, 1, 4); @(negedge clk);
    check("lit_solo_then_g0", rd0_gnt, 1);
    check("lit_solo_then_g1", rd1_gnt, 0);
    next_cycle(); idle(); @(negedge clk);

    // same-address write/read collision returns the new data
    next_cycle(); drive(1, 9, 7'h33, 0, 0, 1, 9); @(negedge clk);
    check("lit_byp_gnt", rd1_gnt, 1);
    next_cycle(); idle(); @(negedge clk);
    check("lit_byp_data", rd1_data, 7'h33);
    next_cycle(); drive(0, 0, 0, 1, 9, 0, 0); @(negedge clk);
    next_cycle(); idle(); @(negedge clk);
    check("lit_byp_landed", rd0_data, 7'h33);

    // different-address write/read in one cycle
    next_cycle(); drive(1, 3, 7'h15, 1, 4, 0, 0); @(negedge clk);
    next_cycle(); idle(); @(negedge clk);
    check("lit_diff_data", rd0_data, 7'h07);
    next_cycle(); drive(0, 0, 0, 1, 3, 0, 0); @(negedge clk);
    next_cycle(); idle(); @(negedge clk);
    check("lit_diff_landed", rd0_data, 7'h15);

    // reset during an in-flight read (pointer currently prefers rd1)
    next_cycle(); drive(0, 0, 0, 1, 5, 0, 0); @(negedge clk);
    check("lit_rst_gnt", rd0_gnt, 1);
    next_cycle(); rst = 1'b0; idle(); @(negedge clk);
    check("lit_rst_drop", rd0_valid, 0);
    next_cycle(); @(negedge clk);
    next_cycle(); rst = 1'b1; @(negedge clk);
    check("lit_rst_after_v0", rd0_valid, 0);
    check("lit_rst_after_v1", rd1_valid, 0);
    next_cycle(); drive(0, 0, 0, 1, 5, 1, 4); @(negedge clk);
    check("lit_rst_rr_g0", rd0_gnt, 1);
    check("lit_rst_rr_g1", rd1_gnt, 0);
    next_cycle(); drive(0, 0, 0, 0, 0, 1, 4); @(negedge clk);
    next_cycle(); idle(); @(negedge clk);

    // random traffic with hold-until-grant requesters, narrow address range
    r0 = 0; r1 = 0; g0 = 0; g1 = 0; a0 = 0; a1 = 0;
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      if (!r0 || g0) begin r0 = 1'($urandom_range(0, 1)); a0 = AW'($urandom_range(0, 7)); end
      if (!r1 || g1) begin r1 = 1'($urandom_range(0, 1)); a1 = AW'($urandom_range(0, 7)); end
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 127)),
            r0, a0, r1, a1);
      @(negedge clk);
      g0 = rd0_gnt; g1 = rd1_gnt;
    end
    next_cycle(); idle();
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_rd_arbiter.md
SRAM_RD_ARBITER -- requirements
Module: sram_rd_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 7, SRAM word width.
REQ-002 SHALL have parameter AWIDTH, default 8, SRAM address width (256 words).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have write-requester ports: wr_req input 1; wr_addr input AWIDTH; wr_data input DWIDTH; wr_gnt output 1.
REQ-006 SHALL have, for each read requester n in {0,1}: rdn_req input 1; rdn_addr input AWIDTH; rdn_gnt output 1; rdn_valid output 1; rdn_data output DWIDTH.
REQ-007 SHALL have SRAM-side ports: sram_wr_en output 1; sram_wr_addr output AWIDTH; sram_d output DWIDTH; sram_rd_en output 1; sram_rd_addr output AWIDTH; sram_q input DWIDTH (valid one cycle after sram_rd_en).

Function
REQ-008 Writes SHALL never stall: wr_gnt = wr_req, sram_wr_en = wr_req, sram_wr_addr = wr_addr, sram_d = wr_data (combinational).
REQ-009 The single SRAM read port SHALL be shared by rd0 and rd1; at most one read grant per cycle.
REQ-010 Grants SHALL be combinational from req and a 1-bit round-robin pointer rr (0 = rd0 preferred, 1 = rd1 preferred).
REQ-011 Only one requester asserting req SHALL be granted regardless of rr.
REQ-012 Both requesting SHALL grant the preferred one; rr SHALL then update to prefer the other.
REQ-013 rr SHALL update only on contested cycles; an uncontested grant SHALL leave rr unchanged.
REQ-014 sram_rd_en SHALL equal rd0_gnt | rd1_gnt; sram_rd_addr SHALL be the granted requester's address, else 0.
REQ-015 A requester SHALL hold req and addr stable until it sees gnt; the arbiter need not tolerate withdrawn requests.
REQ-016 Read latency SHALL be exactly 1 cycle: rdn_valid is high for one cycle, the cycle after rdn_gnt.
REQ-017 A 1-bit registered tag SHALL record which requester owns the in-flight read; only that requester's valid asserts.
REQ-018 Back-to-back grants to one requester SHALL be allowed; valid SHALL then stay high on consecutive cycles.
REQ-019 Read/write collision: a read granted in the same cycle as a write to the same address SHALL return the new wr_data, not the old SRAM contents.
REQ-020 For REQ-019 a registered bypass flag and registered copy of wr_data SHALL be captured on the grant cycle; on the valid cycle rdn_data = bypass ? captured data : sram_q.
REQ-021 A read and a write to different addresses in one cycle SHALL both proceed, and the read SHALL return sram_q.
REQ-022 rdn_data SHALL be driven 0 whenever rdn_valid is low.
REQ-023 rdn_gnt SHALL stay 0 while rdn_req is 0; no response without a grant.

Reset
REQ-024 While rst = 0: rr = 0, tag = 0, bypass flag = 0, captured data = 0, rd0_valid = rd1_valid = 0, rd0_data = rd1_data = 0.
REQ-025 Reset asserted during an in-flight read SHALL drop that response; no valid SHALL appear after reset release.
REQ-026 Combinational outputs (grants, SRAM controls) SHALL follow the inputs during reset; requesters SHALL keep req low during reset.

Verification
REQ-027 Write 0x2A to addr 5, next cycle rd0 reads addr 5 -> rd0_gnt same cycle, rd0_valid next cycle with rd0_data = 0x2A, rd1_valid = 0.
REQ-028 rd0 and rd1 both request continuously for 4 cycles from reset -> grants rd0,rd1,rd0,rd1; valids follow one cycle later in the same order.
REQ-029 rd1 alone for 3 cycles, then both request -> rd1 granted 3 times, rr still 0, so rd0 wins the first contested cycle.
REQ-030 Addr 9 holds 0x11; write 0x33 to addr 9 and rd1 read addr 9 in the same cycle -> rd1_data = 0x33 next cycle; a later read of addr 9 also returns 0x33.
REQ-031 Same cycle: write addr 3 and rd0 read addr 4, where addr 4 holds 0x07 -> rd0_data = 0x07, write lands.
REQ-032 Grant rd0, then pull rst low before the valid cycle -> rd0_valid stays 0; after release rr = 0 and the next contested grant goes to rd0.
